aes_key_sched_seq: RTL and testbench
====================================

// Module: aes_key_sched_seq
// PURPOSE
//  Sequential AES-128 key-schedule engine for aes_cipher_top: expands a loaded 128-bit cipher key
//  into round keys 0..10, one per handshake. Sits upstream of the round datapath (consumer of rk).
//  Time-shares one registered 32-bit SubWord S-box stage (u1-style, output register d) across rounds.
//  Trades throughput (SBOX_LAT+2 cycles/round key) for area, unlike the fully combinational key_expand.
// PARAMETERS
//  NR        10  number of rounds; rk_round counts 0..NR (only 10 supported in this revision)
//  SBOX_LAT   1  S-box output latency in cycles (registered d stage); legal 1..2
// PORTS
//  clk        in   1    single clock, all state updates on posedge
//  rst        in   1    synchronous, active-high reset
//  key_ld     in   1    1-cycle strobe: load key_in and restart schedule at round 0
//  key_in     in   128  cipher key, word0 = key_in[127:96]
//  rk         out  128  current round key {w0,w1,w2,w3}, stable while rk_valid
//  rk_valid   out  1    rk/rk_round valid
//  rk_ready   in   1    consumer accepts rk when rk_valid && rk_ready
//  rk_round   out  4    round index of rk, 0..NR
//  busy       out  1    1 in any state other than IDLE
// BEHAVIOUR
//  Reset (rst=1 at posedge): state=IDLE; rk=0, rk_valid=0, rk_round=0, busy=0; sbox regs cleared.
//  rst has priority over key_ld. key_ld has priority over every other event in every state.
//  FSM states: IDLE, HOLD, LOOKUP, SUB.
//   IDLE  : key_ld -> rk<=key_in, rk_round<=0, -> HOLD (rk_valid=1 the cycle after the strobe).
//   HOLD  : rk_valid=1, rk stable. rk_ready=1: rk_round==NR -> IDLE (rk_valid 0 next cycle);
//           else -> LOOKUP. rk_ready=0: stay, no outputs change.
//   LOOKUP: present RotWord(w3)={w3[23:0],w3[31:24]} to S-box; stays SBOX_LAT cycles (counter).
//   SUB   : t = SubWord ^ {RCON[rk_round],24'h0}; w0'=w0^t; w1'=w1^w0'; w2'=w2^w1'; w3'=w3^w2';
//           rk<={w0',w1',w2',w3'}, rk_round<=rk_round+1, -> HOLD.
//  Latency: handshake in cycle N -> new rk_valid=1 in cycle N+SBOX_LAT+2 (N+3 at default).
//  key_ld mid-schedule (LOOKUP/SUB/HOLD): in-flight round discarded, S-box result ignored; rk<=key_in,
//   rk_round<=0, HOLD next cycle. key_ld coincident with a HOLD handshake: load wins, handshake
//   still counts as consumed for the old rk.
//  RCON indexed by rk_round of the source key (0..9): 01,02,04,08,10,20,40,80,1b,36.
//  rk_round never exceeds NR; no wrap. All XORs are GF(2) bitwise, 32-bit, no carries.
//  rk_valid is low in LOOKUP/SUB/IDLE; rk holds its last value in those states (not cleared).
//  rk_ready while rk_valid=0 has no effect.
// STRUCTURE
//  aes_pkg: word_t (logic [31:0]), RCON[0:9] constant, sbox_f function (256-entry forward S-box),
//   state_e enum {IDLE,HOLD,LOOKUP,SUB}.
//  Sub-module aes_sbox_word_reg: 4x sbox_f on a 32-bit address, SBOX_LAT output register stages,
//   synchronous reset to 0; instantiated once here.
// TESTING
//  T1 reset: rst=1 2 cycles mid-SUB -> next cycle rk=0, rk_valid=0, rk_round=0, busy=0.
//  T2 FIPS-197 A.1: key_in=2b7e1516_28aed2a6_abf71588_09cf4f3c, ready=1 -> rk_round1 =
//     a0fafe17_88542cb1_23a33939_2a6c7605; round10 = d014f9a8_c9ee2589_e13f0cc8_b6630ca6; then IDLE.
//  T3 timing: key_ld cycle 0, ready=1 always -> rk_valid in cycles 1,4,7,...,31; 11 handshakes total.
//  T4 backpressure: hold rk_ready=0 for 5 cycles at round 4 -> rk, rk_round=4 stable, no advance.
//  T5 reload mid-round: key_ld with key_in=0 during LOOKUP of round 3 -> next cycle rk=0, rk_round=0;
//     round1 = 62636363_62636363_62636363_62636363.
//  T6 SBOX_LAT=2 build: rerun T2 -> same keys, handshake-to-valid spacing 4 cycles.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES key-schedule types, round constants and the forward S-box.
package aes_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        LOOKUP = 2'd2,
        SUB    = 2'd3
    } state_e;

    // Round constants, element 0 first (index = round of the source key)
    localparam logic [0:9][7:0] RCON = 80'h01_02_04_08_10_20_40_80_1b_36;

    // Forward S-box, element 0 first (row-major 16 bytes per line)
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox_f(input logic [7:0] a);
        return SBOX[a];
    endfunction

    function automatic word_t subword_f(input word_t w);
        return {sbox_f(w[31:24]), sbox_f(w[23:16]), sbox_f(w[15:8]), sbox_f(w[7:0])};
    endfunction

    // Rounds past the last RCON entry never reach SUB; return 0 defensively
    function automatic logic [7:0] rcon_f(input logic [3:0] r);
        if (r <= 4'd9) return RCON[r];
        return 8'h00;
    endfunction

endpackage

// File: rtl/aes_sbox_word_reg.sv
// Four parallel S-box lookups on a 32-bit word followed by LAT register stages.
module aes_sbox_word_reg
    import aes_pkg::*;
#(
    parameter int LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    output logic [31:0] d
);

    word_t pipe [LAT];

    // Stage 0 registers the substituted word, later stages just delay it
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LAT; i++) pipe[i] <= '0;
        end else begin
            pipe[0] <= subword_f(addr);
            for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
        end
    end

    assign d = pipe[LAT-1];

endmodule

// File: rtl/aes_key_sched_seq.sv
// Sequential AES-128 key expansion: one round key per handshake, sharing a
// single registered SubWord stage across all rounds.
module aes_key_sched_seq
    import aes_pkg::*;
#(
    parameter int NR       = 10,
    parameter int SBOX_LAT = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         key_ld,
    input  logic [127:0] key_in,
    output logic [127:0] rk,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic [3:0]   rk_round,
    output logic         busy
);

    state_e     state;
    logic [1:0] lat_cnt;
    word_t      sub_addr, sub_d, t, w0n, w1n, w2n, w3n;

    // RotWord(w3); rk is frozen during LOOKUP so the address is stable for every stage
    assign sub_addr = {rk[23:0], rk[31:24]};

    aes_sbox_word_reg #(.LAT(SBOX_LAT)) u_sbox (
        .clk  (clk),
        .rst  (rst),
        .addr (sub_addr),
        .d    (sub_d)
    );

    // Next round key words from the registered SubWord result
    always_comb begin
        t   = sub_d ^ {rcon_f(rk_round), 24'h0};
        w0n = rk[127:96] ^ t;
        w1n = rk[95:64]  ^ w0n;
        w2n = rk[63:32]  ^ w1n;
        w3n = rk[31:0]   ^ w2n;
    end

    // Schedule FSM with registered outputs; a key load overrides any state
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            rk       <= '0;
            rk_valid <= 1'b0;
            rk_round <= '0;
            busy     <= 1'b0;
            lat_cnt  <= '0;
        end else if (key_ld) begin
            state    <= HOLD;
            rk       <= key_in;
            rk_valid <= 1'b1;
            rk_round <= '0;
            busy     <= 1'b1;
            lat_cnt  <= '0;
        end else begin
            case (state)
                IDLE: ;
                HOLD: begin
                    if (rk_ready) begin
                        rk_valid <= 1'b0;
                        lat_cnt  <= '0;
                        if (rk_round == 4'(NR)) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            state <= LOOKUP;
                        end
                    end
                end
                LOOKUP: begin
                    if (lat_cnt == 2'(SBOX_LAT - 1)) state <= SUB;
                    else                             lat_cnt <= lat_cnt + 2'd1;
                end
                SUB: begin
                    rk       <= {w0n, w1n, w2n, w3n};
                    rk_round <= rk_round + 4'd1;
                    rk_valid <= 1'b1;
                    state    <= HOLD;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_key_sched_seq.sv
// Directed bench for aes_key_sched_seq: FIPS-197 A.1 expansion, timing,
// backpressure, mid-round reload, reset, and a SBOX_LAT=2 instance.
module tb_aes_key_sched_seq;

    logic         clk = 1'b0;
    logic         rst, key_ld, rk_ready;
    logic [127:0] key_in;
    logic [127:0] rk, rk2;
    logic         rk_valid, rk_valid2, busy, busy2;
    logic [3:0]   rk_round, rk_round2;

    int errors = 0;
    int checks = 0;
    int hs;

    localparam logic [127:0] KA = 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c;
    logic [127:0] exp_rk [0:10];

    always #5 clk = ~clk;

    aes_key_sched_seq #(.NR(10), .SBOX_LAT(1)) dut (
        .clk(clk), .rst(rst), .key_ld(key_ld), .key_in(key_in), .rk(rk),
        .rk_valid(rk_valid), .rk_ready(rk_ready), .rk_round(rk_round), .busy(busy)
    );

    aes_key_sched_seq #(.NR(10), .SBOX_LAT(2)) dut2 (
        .clk(clk), .rst(rst), .key_ld(key_ld), .key_in(key_in), .rk(rk2),
        .rk_valid(rk_valid2), .rk_ready(rk_ready), .rk_round(rk_round2), .busy(busy2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Three cycles from a HOLD handshake to the next round key (SBOX_LAT=1)
    task automatic adv(input int r);
        tick(); tick(); tick();
        chk("adv_valid", 128'(rk_valid), 128'd1);
        chk("adv_round", 128'(rk_round), 128'(r));
        chk("adv_rk", rk, exp_rk[r]);
    endtask

    initial begin
        exp_rk[0]  = KA;
        exp_rk[1]  = 128'ha0fafe17_88542cb1_23a33939_2a6c7605;
        exp_rk[2]  = 128'hf2c295f2_7a96b943_5935807a_7359f67f;
        exp_rk[3]  = 128'h3d80477d_4716fe3e_1e237e44_6d7a883b;
        exp_rk[4]  = 128'hef44a541_a8525b7f_b671253b_db0bad00;
        exp_rk[5]  = 128'hd4d1c6f8_7c839d87_caf2b8bc_11f915bc;
        exp_rk[6]  = 128'h6d88a37a_110b3efd_dbf98641_ca0093fd;
        exp_rk[7]  = 128'h4e54f70e_5f5fc9f3_84a64fb2_4ea6dc4f;
        exp_rk[8]  = 128'head27321_b58dbad2_312bf560_7f8d292f;
        exp_rk[9]  = 128'hac7766f3_19fadc21_28d12941_575c006e;
        exp_rk[10] = 128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6;

        rst = 1'b1; key_ld = 1'b0; rk_ready = 1'b0; key_in = '0;
        tick(); tick();
        rst = 1'b0;
        chk("rst_rk", rk, '0);
        chk("rst_valid", 128'(rk_valid), 128'd0);
        chk("rst_round", 128'(rk_round), 128'd0);
        chk("rst_busy", 128'(busy), 128'd0);

        // FIPS-197 A.1 with rk_ready held high: valid on cycles 1,4,...,31
        key_in = KA; key_ld = 1'b1; rk_ready = 1'b1;
        tick();
        key_ld = 1'b0;
        hs = 0;
        chk("a1_valid0", 128'(rk_valid), 128'd1);
        chk("a1_rk0", rk, exp_rk[0]);
        chk("a1_round0", 128'(rk_round), 128'd0);
        chk("a1_busy0", 128'(busy), 128'd1);
        if (rk_valid) hs++;
        for (int r = 1; r <= 10; r++) begin
            repeat (2) begin
                tick();
                chk("a1_gap_valid", 128'(rk_valid), 128'd0);
                chk("a1_gap_busy", 128'(busy), 128'd1);
                if (rk_valid) hs++;
            end
            tick();
            chk("a1_valid", 128'(rk_valid), 128'd1);
            chk("a1_round", 128'(rk_round), 128'(r));
            chk("a1_rk", rk, exp_rk[r]);
            if (rk_valid) hs++;
        end
        tick();
        chk("a1_end_valid", 128'(rk_valid), 128'd0);
        chk("a1_end_busy", 128'(busy), 128'd0);
        chk("a1_end_rk_hold", rk, exp_rk[10]);
        chk("a1_handshakes", 128'(hs), 128'd11);
        tick();
        chk("idle_stays", 128'(rk_valid), 128'd0);

        // Backpressure at round 4
        key_in = KA; key_ld = 1'b1;
        tick();
        key_ld = 1'b0;
        for (int r = 1; r <= 3; r++) adv(r);
        adv(4);
        rk_ready = 1'b0;
        repeat (5) begin
            tick();
            chk("bp_valid", 128'(rk_valid), 128'd1);
            chk("bp_round", 128'(rk_round), 128'd4);
            chk("bp_rk", rk, exp_rk[4]);
        end
        rk_ready = 1'b1;
        tick();
        chk("bp_release", 128'(rk_valid), 128'd0);
        tick(); tick();
        chk("bp_r5_round", 128'(rk_round), 128'd5);
        chk("bp_r5_rk", rk, exp_rk[5]);

        // Reset asserted for two cycles while in SUB
        tick(); tick();
        chk("sub_busy", 128'(busy), 128'd1);
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        chk("midrst_rk", rk, '0);
        chk("midrst_valid", 128'(rk_valid), 128'd0);
        chk("midrst_round", 128'(rk_round), 128'd0);
        chk("midrst_busy", 128'(busy), 128'd0);

        // Reload with zero key during the lookup for round 3
        key_in = KA; key_ld = 1'b1;
        tick();
        key_ld = 1'b0;
        adv(1); adv(2);
        tick();
        chk("rl_lookup_valid", 128'(rk_valid), 128'd0);
        key_in = '0; key_ld = 1'b1;
        tick();
        key_ld = 1'b0;
        chk("rl_rk0", rk, '0);
        chk("rl_round0", 128'(rk_round), 128'd0);
        chk("rl_valid0", 128'(rk_valid), 128'd1);
        tick(); tick(); tick();
        chk("rl_round1", 128'(rk_round), 128'd1);
        chk("rl_rk1", rk, 128'h62636363_62636363_62636363_62636363);

        // SBOX_LAT=2 instance: same keys, four cycles per round
        key_in = KA; key_ld = 1'b1;
        tick();
        key_ld = 1'b0;
        chk("l2_rk0", rk2, exp_rk[0]);
        chk("l2_valid0", 128'(rk_valid2), 128'd1);
        for (int r = 1; r <= 10; r++) begin
            repeat (3) begin
                tick();
                chk("l2_gap_valid", 128'(rk_valid2), 128'd0);
            end
            tick();
            chk("l2_valid", 128'(rk_valid2), 128'd1);
            chk("l2_round", 128'(rk_round2), 128'(r));
            chk("l2_rk", rk2, exp_rk[r]);
        end
        tick();
        chk("l2_end_busy", 128'(busy2), 128'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
